// File: rtl/la_capture_ctrl_if.sv
// Logic-analyser capture controller bundle: sample strobe, capture control,
// RAM write port and capture result signals.
// master: the side that drives samples/commands and reads results.
// slave : the capture controller itself.
interface la_capture_ctrl_if #(
  parameter int AW = 17
);
  logic          sample_en;
  logic          arm;
  logic          abort;
  logic          trig_hit;
  logic [AW-1:0] pretrig_len;

  logic [AW-1:0] wr_addr;
  logic          wren;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
  logic          timed_out;

  modport master (
    output sample_en, arm, abort, trig_hit, pretrig_len,
    input  wr_addr, wren, busy, done, trig_addr, start_addr, timed_out
  );

  modport slave (
    input  sample_en, arm, abort, trig_hit, pretrig_len,
    output wr_addr, wren, busy, done, trig_addr, start_addr, timed_out
  );
endinterface

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller.
// Fills a circular sample RAM of 2^AW entries: pretrig_len samples before
// the trigger, the trigger sample, and the rest of the buffer after it.
// Optional macro LA_TIMEOUT_EN: forces a trigger after TIMEOUT_CYC cycles
// spent waiting for one, and reports it on timed_out.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   IDLE      | no capture; RAM untouched
//   PRE       | filling the pre-trigger history, trig_hit ignored
//   WAIT_TRIG | circular writes, waiting for a qualified trigger
//   POST      | filling the remainder of the buffer after trigger
//   DONE      | capture complete; addresses held until next arm
module la_capture_ctrl #(
  parameter int          AW          = 17,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
  input logic          clk_50M,
  input logic          rst,
  la_capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] trig_addr_q;
  logic [AW-1:0] start_addr_q;
  logic [AW-1:0] plen_q;
  logic [AW-1:0] pre_cnt_q;
  logic [AW-1:0] post_cnt_q;
  logic          busy_q;
  logic          done_q;

  logic          active;
  logic          wr_en;
  logic          force_hit;
  logic          hit_eff;
  logic [AW-1:0] post_load;
  logic          arm_ok;

  // Writes are gated by reset so the reset cycle never touches the RAM.
  assign active    = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
  assign wr_en     = bus.sample_en & active & ~rst;
  assign post_load = {AW{1'b1}} - plen_q;
  assign hit_eff   = bus.trig_hit | force_hit;
  assign arm_ok    = bus.arm & ~bus.abort & ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef LA_TIMEOUT_EN
  logic [23:0] to_cnt_q;
  logic        to_reached;
  logic        timed_out_q;

  // Saturates at the terminal value so a late write still sees the timeout.
  assign to_reached = (to_cnt_q == TIMEOUT_CYC - 24'd1);
  assign force_hit  = to_reached;

  // Wait-time counter: zero outside WAIT_TRIG, counts every cycle inside it.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q != S_WAIT_TRIG) begin
      to_cnt_q <= '0;
    end else if (!to_reached) begin
      to_cnt_q <= to_cnt_q + 24'd1;
    end
  end

  // Sticky forced-trigger flag; abort leaves it alone, arm clears it.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      timed_out_q <= 1'b0;
    end else if (arm_ok) begin
      timed_out_q <= 1'b0;
    end else if (!bus.abort && state_q == S_WAIT_TRIG && wr_en && to_reached && !bus.trig_hit) begin
      timed_out_q <= 1'b1;
    end
  end

  assign bus.timed_out = timed_out_q;
`else
  assign force_hit     = 1'b0;
  assign bus.timed_out = 1'b0;
`endif

  // Capture FSM with its address pointers, counters and status flags.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      plen_q       <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (bus.abort) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_addr_q <= wr_addr_q + AW'(1);
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.arm) begin
            plen_q    <= bus.pretrig_len;
            pre_cnt_q <= bus.pretrig_len;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= (bus.pretrig_len != '0) ? S_PRE : S_WAIT_TRIG;
          end
        end
        S_PRE: begin
          if (wr_en) begin
            pre_cnt_q <= pre_cnt_q - AW'(1);
            if (pre_cnt_q == AW'(1)) begin
              state_q <= S_WAIT_TRIG;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (wr_en && hit_eff) begin
            trig_addr_q  <= wr_addr_q;
            start_addr_q <= wr_addr_q - plen_q;
            post_cnt_q   <= post_load;
            // A full-buffer pre-trigger leaves no post samples to take.
            if (post_load == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_POST;
            end
          end
        end
        S_POST: begin
          if (wr_en) begin
            post_cnt_q <= post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_addr    = wr_addr_q;
  assign bus.wren       = wr_en;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.trig_addr  = trig_addr_q;
  assign bus.start_addr = start_addr_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl with a 16-entry buffer. The reference model
// works in terms of write indices: the trigger is the first write at or
// after the pre-trigger length whose hit flag is set (or that falls late
// enough in the trigger wait when LA_TIMEOUT_EN is defined), and the
// capture ends 2^AW - pretrig_len writes after the trigger write.
module tb_la_capture_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TO    = 10;
`ifdef LA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_50M = 1'b0;
  logic rst;
  always #10 clk_50M = ~clk_50M;

  la_capture_ctrl_if #(.AW(AW)) bus ();

  la_capture_ctrl #(.AW(AW), .TIMEOUT_CYC(24'(TO))) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit hitw [0:255];
  int obs_writes;

  task automatic clear_hits();
    for (int i = 0; i < 256; i++) hitw[i] = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst = 1'b1; bus.arm = 1'b1; bus.abort = 1'b0; bus.sample_en = 1'b1;
    bus.trig_hit = 1'b1; bus.pretrig_len = 4'd5;
    repeat (3) @(negedge clk_50M);
    #1;
    got = {bus.wren, bus.busy, bus.done, bus.wr_addr, bus.trig_addr, bus.start_addr, bus.timed_out};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0000", got);
    end
    @(negedge clk_50M);
    rst = 1'b0; bus.arm = 1'b0; bus.sample_en = 1'b1;
    @(negedge clk_50M);
    #1;
    checks++;
    if ({bus.wren, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=000", {bus.wren, bus.busy, bus.done});
    end
  endtask

  // Runs one capture from IDLE/DONE, checking every cycle against the model.
  task automatic run_capture(input int plen, input int se_per, input bit arm_noise);
    int w = 0, c = 0, k = -1, total = 0, waitc = 0;
    bit timed = 1'b0, se, in_wait;
    logic [6:0]  got7, exp7;
    logic [15:0] got, exp;
    obs_writes = 0;
    @(negedge clk_50M);
    bus.arm = 1'b1; bus.abort = 1'b0; bus.sample_en = 1'b0;
    bus.trig_hit = 1'b0; bus.pretrig_len = AW'(plen);
    while (!(k >= 0 && w >= total) && c < 800) begin
      @(negedge clk_50M);
      se = (se_per == 0) ? 1'($urandom_range(0, 1)) : (c % se_per == 0);
      bus.sample_en   = se;
      bus.trig_hit    = se ? hitw[w] : 1'($urandom_range(0, 1));
      bus.arm         = arm_noise && ($urandom_range(0, 7) == 0);
      bus.pretrig_len = arm_noise ? AW'($urandom) : AW'(plen);
      #1;
      got7 = {bus.wren, bus.busy, bus.done, bus.wr_addr};
      exp7 = {se, 1'b1, 1'b0, AW'(w % DEPTH)};
      checks++;
      if (got7 !== exp7) begin
        errors++;
        $display("FAIL capture_cycle plen=%0d c=%0d w=%0d got=%b exp=%b", plen, c, w, got7, exp7);
      end
      if (bus.wren) obs_writes++;
      in_wait = (w >= plen) && (k < 0);
      if (se && in_wait && (hitw[w] || (TO_EN && waitc >= TO - 1))) begin
        k     = w;
        timed = !hitw[w];
        total = k + DEPTH - plen;
      end
      if (in_wait) waitc++;
      if (se) w++;
      c++;
    end
    @(negedge clk_50M);
    bus.arm = 1'b0; bus.sample_en = 1'b1; bus.trig_hit = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (c >= 800) begin
      errors++;
      $display("FAIL capture_budget plen=%0d cycles=%0d got=no_end exp=done", plen, c);
    end else begin
      got = {bus.wren, bus.busy, bus.done, bus.wr_addr, bus.trig_addr, bus.start_addr, bus.timed_out};
      exp = {1'b0, 1'b0, 1'b1, AW'(total % DEPTH), AW'(k % DEPTH), AW'((k - plen) % DEPTH), timed};
      if (got !== exp) begin
        errors++;
        $display("FAIL capture_end plen=%0d k=%0d got=%h exp=%h", plen, k, got, exp);
      end
    end
  endtask

  task automatic test_pretrig5();
    clear_hits(); hitw[7] = 1'b1; hitw[30] = 1'b1;
    run_capture(5, 1, 1'b0);
    checks++;
    if ({bus.trig_addr, bus.start_addr, bus.wr_addr} !== {4'd7, 4'd2, 4'd2} || obs_writes != 18) begin
      errors++;
      $display("FAIL pretrig5 got trig=%0d start=%0d wr=%0d writes=%0d exp trig=7 start=2 wr=2 writes=18",
               bus.trig_addr, bus.start_addr, bus.wr_addr, obs_writes);
    end
  endtask

  task automatic test_pretrig0();
    clear_hits(); hitw[0] = 1'b1;
    run_capture(0, 1, 1'b0);
    checks++;
    if ({bus.trig_addr, bus.start_addr, bus.wr_addr} !== 12'h000 || obs_writes != 16) begin
      errors++;
      $display("FAIL pretrig0 got trig=%0d start=%0d wr=%0d writes=%0d exp trig=0 start=0 wr=0 writes=16",
               bus.trig_addr, bus.start_addr, bus.wr_addr, obs_writes);
    end
  endtask

  task automatic test_pretrig15();
    clear_hits(); hitw[19] = 1'b1;
    run_capture(15, 1, 1'b0);
    checks++;
    if ({bus.trig_addr, bus.start_addr, bus.wr_addr} !== {4'd3, 4'd4, 4'd4} || obs_writes != 20) begin
      errors++;
      $display("FAIL pretrig15 got trig=%0d start=%0d wr=%0d writes=%0d exp trig=3 start=4 wr=4 writes=20",
               bus.trig_addr, bus.start_addr, bus.wr_addr, obs_writes);
    end
  endtask

  task automatic test_pre_hit_ignored();
    clear_hits(); hitw[1] = 1'b1; hitw[9] = 1'b1;
    run_capture(5, 1, 1'b1);
    checks++;
    if ({bus.trig_addr, bus.start_addr} !== {4'd9, 4'd4} || obs_writes != 20) begin
      errors++;
      $display("FAIL pre_hit_ignored got trig=%0d start=%0d writes=%0d exp trig=9 start=4 writes=20",
               bus.trig_addr, bus.start_addr, obs_writes);
    end
  endtask

  task automatic test_random();
    int plen;
    for (int n = 0; n < 12; n++) begin
      plen = $urandom_range(0, DEPTH - 1);
      clear_hits();
      for (int i = 0; i < 256; i++) hitw[i] = ($urandom_range(0, 5) == 0);
      hitw[plen + 20] = 1'b1;
      run_capture(plen, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_abort();
    int w = 0;
    bit se;
    @(negedge clk_50M);
    bus.arm = 1'b1; bus.pretrig_len = 4'd3; bus.sample_en = 1'b0; bus.trig_hit = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_50M);
      bus.arm = 1'b0;
      se = (c % 4 == 0);
      bus.sample_en = se;
      bus.trig_hit  = se && (w == 3);
      bus.abort     = (c == 15);
      if (se) w++;
    end
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      errors++;
      $display("FAIL abort_pre_state got=%b exp=10", {bus.busy, bus.done});
    end
    @(negedge clk_50M);
    bus.abort = 1'b0; bus.sample_en = 1'b1;
    #1;
    checks++;
    if ({bus.wren, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_to_idle got=%b exp=000", {bus.wren, bus.busy, bus.done});
    end
    @(negedge clk_50M);
    bus.arm = 1'b1; bus.abort = 1'b1; bus.pretrig_len = 4'd2;
    @(negedge clk_50M);
    bus.arm = 1'b0; bus.abort = 1'b0; bus.sample_en = 1'b1;
    #1;
    checks++;
    if ({bus.wren, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL arm_abort_same_cycle got=%b exp=000", {bus.wren, bus.busy, bus.done});
    end
  endtask

  task automatic test_rst_mid_post();
    logic [15:0] got;
    @(negedge clk_50M);
    bus.arm = 1'b1; bus.pretrig_len = 4'd2; bus.sample_en = 1'b0; bus.trig_hit = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_50M);
      bus.arm = 1'b0; bus.sample_en = 1'b1; bus.trig_hit = (c == 2);
      if (c == 5) rst = 1'b1;
    end
    #1;
    checks++;
    if ({bus.wren, bus.trig_addr} !== {1'b0, 4'd2}) begin
      errors++;
      $display("FAIL rst_cycle_write got wren=%b trig=%0d exp wren=0 trig=2", bus.wren, bus.trig_addr);
    end
    @(negedge clk_50M);
    rst = 1'b0; bus.sample_en = 1'b0; bus.trig_hit = 1'b0;
    #1;
    got = {bus.wren, bus.busy, bus.done, bus.wr_addr, bus.trig_addr, bus.start_addr, bus.timed_out};
    checks++;
    if (got !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_post got=%h exp=0000", got);
    end
  endtask

`ifdef LA_TIMEOUT_EN
  task automatic test_timeout();
    clear_hits();
    run_capture(2, 1, 1'b0);
    checks++;
    if ({bus.trig_addr, bus.start_addr, bus.timed_out} !== {4'd11, 4'd9, 1'b1} || obs_writes != 25) begin
      errors++;
      $display("FAIL timeout_forced got trig=%0d start=%0d to=%b writes=%0d exp trig=11 start=9 to=1 writes=25",
               bus.trig_addr, bus.start_addr, bus.timed_out, obs_writes);
    end
    clear_hits(); hitw[0] = 1'b1;
    run_capture(0, 1, 1'b0);
  endtask
`else
  task automatic test_timeout();
    @(negedge clk_50M);
    bus.arm = 1'b1; bus.pretrig_len = 4'd2; bus.sample_en = 1'b0; bus.trig_hit = 1'b0;
    repeat (1000) begin
      @(negedge clk_50M);
      bus.arm = 1'b0; bus.sample_en = 1'b1; bus.trig_hit = 1'b0;
    end
    @(negedge clk_50M);
    bus.sample_en = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.timed_out, bus.wr_addr} !== {3'b100, 4'd8}) begin
      errors++;
      $display("FAIL no_timeout got=%b exp=1008", {bus.busy, bus.done, bus.timed_out, bus.wr_addr});
    end
    @(negedge clk_50M);
    bus.abort = 1'b1;
    @(negedge clk_50M);
    bus.abort = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.sample_en = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0;
    bus.trig_hit = 1'b0; bus.pretrig_len = '0;
    test_reset();
    test_pretrig5();
    test_pretrig0();
    test_pretrig15();
    test_pre_hit_ignored();
    test_random();
    test_abort();
    test_rst_mid_post();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
